// File: rtl/imm_serializer.sv
// imm_serializer
//   Loads an N-bit immediate operand and streams it to the PIM column drivers
//   W bits per step, LSB-first or MSB-first, with a programmable operand length.
//   With W=1 it behaves as the legacy bit-serial immediate shift register.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   D            immediate operand
//   len          number of valid operand bits D[len-1:0] (clamped to N)
//   dir          0 = LSB-first, 1 = MSB-first
//   PIM_load     load D/len/dir and start a new stream (wins over Update_load)
//   Update_load  consumer advance, honoured only while out_valid=1
//   Q            internal shift register (debug/legacy observation)
//   out_bits     current chunk, invalid bit positions forced to 0
//   out_valid    out_bits holds valid data
//   out_last     current chunk is the final one
//   rem          bits still to be emitted, including the current chunk
//   done         one-cycle pulse after the final chunk is accepted
module imm_serializer #(
    parameter int N  = 25,
    parameter int W  = 1,
    parameter int LW = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  D,
    input  logic [LW-1:0] len,
    input  logic          dir,
    input  logic          PIM_load,
    input  logic          Update_load,
    output logic [N-1:0]  Q,
    output logic [W-1:0]  out_bits,
    output logic          out_valid,
    output logic          out_last,
    output logic [LW-1:0] rem,
    output logic          done
);

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        FIN
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [N-1:0]  q;
    logic [LW-1:0] rem_q;
    logic          dir_q;

    logic [LW-1:0] len_eff;
    logic [N-1:0]  d_masked;
    logic [N-1:0]  load_val;
    logic          advance;
    logic [W-1:0]  chunk;
    logic [W-1:0]  chunk_mask;

    // Load-side operand preparation. An MSB-first operand is left-justified so
    // its first bit sits at Q[N-1], which lets both directions share one shifter.
    always_comb begin
        len_eff  = (len > LW'(N)) ? LW'(N) : len;
        // A shift by len_eff == N yields all zeros, so the mask becomes all ones.
        d_masked = D & ~({N{1'b1}} << len_eff);
        load_val = dir ? (d_masked << (LW'(N) - len_eff)) : d_masked;
        advance  = out_valid & Update_load & ~PIM_load;
    end

    // NOTE: every signal written in a combinational block gets a default first,
    // otherwise a path that skips the assignment infers a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = IDLE;
            STREAM:  if (advance && (rem_q <= LW'(W))) state_nxt = FIN;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // A load aborts whatever is in flight; an aborted stream never reaches FIN.
        if (PIM_load) state_nxt = (len_eff == '0) ? FIN : STREAM;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q     <= '0;
            rem_q <= '0;
            dir_q <= 1'b0;
        end else if (PIM_load) begin
            q     <= load_val;
            rem_q <= len_eff;
            dir_q <= dir;
        end else if (advance) begin
            q     <= dir_q ? (q << W) : (q >> W);
            rem_q <= (rem_q > LW'(W)) ? (rem_q - LW'(W)) : '0;
        end
    end

    // When fewer than W bits remain, only the rem bits nearest the output end
    // are real. rem is 0 outside STREAM, so the mask also blanks idle output.
    always_comb begin
        chunk      = dir_q ? q[N-1:N-W] : q[W-1:0];
        chunk_mask = dir_q ? ~({W{1'b1}} >> rem_q) : ~({W{1'b1}} << rem_q);
        out_bits   = chunk & chunk_mask;
    end

    assign Q         = q;
    assign rem       = rem_q;
    assign out_valid = (state == STREAM);
    assign done      = (state == FIN);
    assign out_last  = out_valid & (rem_q <= LW'(W));

endmodule

// File: tb/tb_imm_serializer.sv
// Bench for imm_serializer: three instances (W=1, W=4, W=25, all N=25) share
// one stimulus stream and are compared against a bit-sequence reference model.
module tb_imm_serializer;

    localparam int N  = 25;
    localparam int LW = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  D;
    logic [LW-1:0] len;
    logic          dir;
    logic          PIM_load;
    logic          Update_load;

    logic [N-1:0]  q1, q4, q25;
    logic [0:0]    ob1;
    logic [3:0]    ob4;
    logic [24:0]   ob25;
    logic          v1, v4, v25, l1, l4, l25, d1, d4, d25;
    logic [LW-1:0] r1, r4, r25;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    imm_serializer #(.N(N), .W(1)) u_w1 (
        .clk(clk), .rst_n(rst_n), .D(D), .len(len), .dir(dir),
        .PIM_load(PIM_load), .Update_load(Update_load),
        .Q(q1), .out_bits(ob1), .out_valid(v1), .out_last(l1), .rem(r1), .done(d1)
    );
    imm_serializer #(.N(N), .W(4)) u_w4 (
        .clk(clk), .rst_n(rst_n), .D(D), .len(len), .dir(dir),
        .PIM_load(PIM_load), .Update_load(Update_load),
        .Q(q4), .out_bits(ob4), .out_valid(v4), .out_last(l4), .rem(r4), .done(d4)
    );
    imm_serializer #(.N(N), .W(25)) u_w25 (
        .clk(clk), .rst_n(rst_n), .D(D), .len(len), .dir(dir),
        .PIM_load(PIM_load), .Update_load(Update_load),
        .Q(q25), .out_bits(ob25), .out_valid(v25), .out_last(l25), .rem(r25), .done(d25)
    );

    typedef struct packed {
        logic [24:0] q;
        logic [24:0] ob;
        logic        valid;
        logic        last;
        logic [4:0]  rem;
        logic        done;
    } obs_t;

    // Reference model: the operand as a bit sequence plus a count of bits
    // already consumed. st: 0 idle, 1 streaming, 2 done pulse.
    typedef struct {
        logic [24:0] d;
        int          len;
        bit          dir;
        int          cons;
        int          st;
    } model_t;

    model_t m [3];

    function automatic int wv(input int k);
        return (k == 0) ? 1 : (k == 1) ? 4 : 25;
    endfunction

    function automatic obs_t actual(input int k);
        obs_t a;
        a = '0;
        case (k)
            0: begin a.q = q1;  a.ob = 25'(ob1);  a.valid = v1;  a.last = l1;  a.rem = r1;  a.done = d1;  end
            1: begin a.q = q4;  a.ob = 25'(ob4);  a.valid = v4;  a.last = l4;  a.rem = r4;  a.done = d4;  end
            default: begin a.q = q25; a.ob = ob25; a.valid = v25; a.last = l25; a.rem = r25; a.done = d25; end
        endcase
        return a;
    endfunction

    function automatic obs_t expected(input int k);
        obs_t e;
        int   w;
        int   r;
        int   idx;
        e = '0;
        w = wv(k);
        r = (m[k].st == 1) ? (m[k].len - m[k].cons) : 0;
        e.valid = (m[k].st == 1);
        e.done  = (m[k].st == 2);
        e.rem   = r[4:0];
        e.last  = e.valid && (r <= w);
        if (!m[k].dir) e.q = m[k].d >> m[k].cons;
        else           e.q = (m[k].d << (N - m[k].len)) << m[k].cons;
        for (int i = 0; i < w && i < r; i++) begin
            if (!m[k].dir) begin
                idx = m[k].cons + i;
                e.ob[i] = m[k].d[idx];
            end else begin
                idx = m[k].len - 1 - m[k].cons - i;
                e.ob[w-1-i] = m[k].d[idx];
            end
        end
        return e;
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < 3; k++) begin
            m[k].d = '0; m[k].len = 0; m[k].dir = 1'b0; m[k].cons = 0; m[k].st = 0;
        end
    endfunction

    function automatic void model_clock();
        int          le;
        logic [24:0] mk;
        if (!rst_n) begin
            model_reset();
            return;
        end
        for (int k = 0; k < 3; k++) begin
            if (PIM_load) begin
                le = (int'(len) > N) ? N : int'(len);
                mk = (le >= N) ? '1 : ((25'd1 << le) - 25'd1);
                m[k].d    = D & mk;
                m[k].len  = le;
                m[k].dir  = dir;
                m[k].cons = 0;
                m[k].st   = (le > 0) ? 1 : 2;
            end else if (m[k].st == 1 && Update_load) begin
                m[k].cons += wv(k);
                if (m[k].cons >= m[k].len) m[k].st = 2;
            end else if (m[k].st == 2) begin
                m[k].st = 0;
            end
        end
    endfunction

    // Drive inputs, take one rising edge, advance the model, settle.
    task automatic step(input bit pim, input bit upd, input logic [24:0] d,
                        input int l, input bit dr);
        PIM_load    = pim;
        Update_load = upd;
        D           = d;
        len         = l[4:0];
        dir         = dr;
        @(posedge clk);
        model_clock();
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; PIM_load = 1'b0; Update_load = 1'b0; D = '0; len = '0; dir = 1'b0;
        model_reset();
        #12;
        for (int k = 0; k < 3; k++) begin
            total++;
            if (actual(k) !== expected(k)) begin
                bad++;
                $display("FAIL reset k=%0d got=%h want=%h", k, actual(k), expected(k));
            end
        end
        rst_n = 1'b1;
        @(posedge clk);
        model_clock();
        #1;
    endtask

    task automatic test_reset_midstream();
        step(1'b1, 1'b0, 25'h1FFFFFF, 25, 1'b0);
        repeat (3) step(1'b0, 1'b1, 25'h1FFFFFF, 25, 1'b0);
        total++;
        if (r1 !== 5'd22) begin
            bad++;
            $display("FAIL midstream_rem got=%0d want=22", r1);
        end
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        total++;
        if ({q1, ob1, v1, l1, r1, d1} !== '0) begin
            bad++;
            $display("FAIL async_reset_w1 got=%h want=0", {q1, ob1, v1, l1, r1, d1});
        end
        for (int k = 0; k < 3; k++) begin
            total++;
            if (actual(k) !== expected(k)) begin
                bad++;
                $display("FAIL async_reset k=%0d got=%h want=%h", k, actual(k), expected(k));
            end
        end
        repeat (2) begin
            step(1'b0, 1'b1, 25'h1FFFFFF, 25, 1'b0);
            total++;
            if ({d1, d4, d25} !== 3'b000) begin
                bad++;
                $display("FAIL reset_no_done got=%b want=000", {d1, d4, d25});
            end
        end
        rst_n = 1'b1;
        step(1'b0, 1'b0, '0, 0, 1'b0);
    endtask

    task automatic test_lsb_chunks();
        logic [3:0] nib [7];
        nib = '{4'hF, 4'hE, 4'hD, 4'hC, 4'hB, 4'hA, 4'h1};
        step(1'b1, 1'b1, 25'h1ABCDEF, 25, 1'b0);
        for (int i = 0; i < 7; i++) begin
            total++;
            if (ob4 !== nib[i] || r4 !== 5'(25 - 4 * i) || l4 !== (i == 6) || v4 !== 1'b1) begin
                bad++;
                $display("FAIL lsb_chunk%0d got=%h/%0d/%b want=%h/%0d/%b",
                         i, ob4, r4, l4, nib[i], 25 - 4 * i, (i == 6));
            end
            total++;
            if (actual(1) !== expected(1)) begin
                bad++;
                $display("FAIL lsb_model%0d got=%h want=%h", i, actual(1), expected(1));
            end
            step(1'b0, 1'b1, 25'h1ABCDEF, 25, 1'b0);
        end
        total++;
        if (d4 !== 1'b1 || v4 !== 1'b0) begin
            bad++;
            $display("FAIL lsb_done got=%b%b want=10", d4, v4);
        end
        step(1'b0, 1'b0, '0, 0, 1'b0);
        total++;
        if (d4 !== 1'b0) begin
            bad++;
            $display("FAIL lsb_done_width got=%b want=0", d4);
        end
    endtask

    task automatic test_msb_short();
        step(1'b1, 1'b0, 25'h00000A5, 8, 1'b1);
        total++;
        if (ob4 !== 4'hA || l4 !== 1'b0) begin
            bad++;
            $display("FAIL msb8_c0 got=%h/%b want=a/0", ob4, l4);
        end
        step(1'b0, 1'b1, 25'h00000A5, 8, 1'b1);
        total++;
        if (ob4 !== 4'h5 || l4 !== 1'b1) begin
            bad++;
            $display("FAIL msb8_c1 got=%h/%b want=5/1", ob4, l4);
        end
        step(1'b0, 1'b1, 25'h00000A5, 8, 1'b1);
        total++;
        if (d4 !== 1'b1) begin
            bad++;
            $display("FAIL msb8_done got=%b want=1", d4);
        end
        step(1'b1, 1'b0, 25'h00000A5, 6, 1'b1);
        total++;
        if (ob4 !== 4'h9 || r4 !== 5'd6) begin
            bad++;
            $display("FAIL msb6_c0 got=%h/%0d want=9/6", ob4, r4);
        end
        step(1'b0, 1'b1, 25'h00000A5, 6, 1'b1);
        total++;
        if (ob4 !== 4'h4 || l4 !== 1'b1 || r4 !== 5'd2) begin
            bad++;
            $display("FAIL msb6_c1 got=%h/%b/%0d want=4/1/2", ob4, l4, r4);
        end
        for (int k = 0; k < 3; k++) begin
            total++;
            if (actual(k) !== expected(k)) begin
                bad++;
                $display("FAIL msb_model k=%0d got=%h want=%h", k, actual(k), expected(k));
            end
        end
        repeat (2) step(1'b0, 1'b0, '0, 0, 1'b0);
    endtask

    task automatic test_stall_idle();
        bit          pat  [5];
        logic        obx  [5];
        logic [24:0] qx   [5];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        obx = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        qx  = '{25'd5, 25'd2, 25'd2, 25'd2, 25'd1};
        step(1'b1, 1'b0, 25'd5, 3, 1'b0);
        for (int i = 0; i < 5; i++) begin
            total++;
            if (ob1 !== obx[i] || q1 !== qx[i]) begin
                bad++;
                $display("FAIL stall%0d got=%b/%h want=%b/%h", i, ob1, q1, obx[i], qx[i]);
            end
            step(1'b0, pat[i], 25'd5, 3, 1'b0);
        end
        total++;
        if (d1 !== 1'b1) begin
            bad++;
            $display("FAIL stall_done got=%b want=1", d1);
        end
        repeat (3) begin
            step(1'b0, 1'b1, 25'h1FFFFFF, 25, 1'b0);
            for (int k = 0; k < 3; k++) begin
                total++;
                if (actual(k) !== expected(k)) begin
                    bad++;
                    $display("FAIL idle_adv k=%0d got=%h want=%h", k, actual(k), expected(k));
                end
            end
        end
    endtask

    task automatic test_abort();
        int dones;
        step(1'b1, 1'b0, 25'($urandom()), 20, 1'b0);
        repeat (3) step(1'b0, 1'b1, '0, 0, 1'b0);
        step(1'b1, 1'b1, 25'd3, 2, 1'b0);
        total++;
        if (r1 !== 5'd2 || ob1 !== 1'b1 || d1 !== 1'b0) begin
            bad++;
            $display("FAIL abort_load got=%0d/%b/%b want=2/1/0", r1, ob1, d1);
        end
        dones = 0;
        repeat (4) begin
            for (int k = 0; k < 3; k++) begin
                total++;
                if (actual(k) !== expected(k)) begin
                    bad++;
                    $display("FAIL abort_model k=%0d got=%h want=%h", k, actual(k), expected(k));
                end
            end
            step(1'b0, 1'b1, '0, 0, 1'b0);
            dones += int'(d1);
        end
        total++;
        if (dones !== 1) begin
            bad++;
            $display("FAIL abort_done_count got=%0d want=1", dones);
        end
    endtask

    task automatic test_corners();
        logic [24:0] dv;
        step(1'b1, 1'b1, 25'($urandom()), 0, 1'b0);
        total++;
        if ({v1, v4, v25} !== 3'b000 || {d1, d4, d25} !== 3'b111) begin
            bad++;
            $display("FAIL len0 got=%b%b want=000111", {v1, v4, v25}, {d1, d4, d25});
        end
        step(1'b0, 1'b1, '0, 0, 1'b0);
        total++;
        if ({v1, v4, v25, d1, d4, d25} !== 6'b0) begin
            bad++;
            $display("FAIL len0_after got=%b want=000000", {v1, v4, v25, d1, d4, d25});
        end
        for (int dr = 0; dr < 2; dr++) begin
            dv = 25'($urandom());
            step(1'b1, 1'b0, dv, 31, dr[0]);
            total++;
            if (r1 !== 5'd25 || r25 !== 5'd25 || ob25 !== dv || l25 !== 1'b1) begin
                bad++;
                $display("FAIL clamp_full dir=%0d got=%0d/%0d/%h/%b want=25/25/%h/1",
                         dr, r1, r25, ob25, l25, dv);
            end
            step(1'b0, 1'b1, '0, 0, 1'b0);
            total++;
            if (d25 !== 1'b1 || v25 !== 1'b0) begin
                bad++;
                $display("FAIL full_done dir=%0d got=%b%b want=10", dr, d25, v25);
            end
        end
        repeat (30) step(1'b0, 1'b1, '0, 0, 1'b0);
    endtask

    task automatic test_back_to_back();
        step(1'b1, 1'b0, 25'h00000C, 4, 1'b0);
        step(1'b0, 1'b1, '0, 0, 1'b0);
        step(1'b1, 1'b0, 25'h00005A, 8, 1'b1);
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < 3; k++) begin
                total++;
                if (actual(k) !== expected(k)) begin
                    bad++;
                    $display("FAIL b2b%0d k=%0d got=%h want=%h", i, k, actual(k), expected(k));
                end
            end
            step(1'b0, 1'b1, '0, 0, 1'b0);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 7) == 0), $urandom_range(0, 1) == 1,
                 25'($urandom()), int'($urandom_range(0, 31)), $urandom_range(0, 1) == 1);
            for (int k = 0; k < 3; k++) begin
                total++;
                if (actual(k) !== expected(k)) begin
                    bad++;
                    $display("FAIL random%0d k=%0d got=%h want=%h", i, k, actual(k), expected(k));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_reset_midstream();
        test_lsb_chunks();
        test_msb_short();
        test_stall_idle();
        test_abort();
        test_corners();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
